// File: rtl/snn_pkg.sv
// Shared SNN definitions: default counter widths and the rate-decoder FSM state type.
package snn_pkg;
    localparam int SNN_CNT_W = 8;
    localparam int SNN_WIN_W = 8;

    typedef enum logic {IDLE, COUNT} dec_state_t;
endpackage

// File: rtl/spike_edge_det.sv
// Rising-edge detector for a spike line: one pulse per 0->1 transition of axon.
module spike_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic axon,
    output logic spike
);
    logic axon_q;

    always_ff @(posedge clk) begin
        if (rst) axon_q <= 1'b0;
        else     axon_q <= axon;
    end

    // Cleared on reset so a line already high after reset still yields one spike.
    assign spike = axon & ~axon_q;
endmodule

// File: rtl/spike_rate_decoder.sv
// Counts axon spikes per programmable window and hands each count out on a valid/ready port.
// Optional SPIKE_RATE_DECODER_ISI_EN adds an inter-spike-interval output.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = SNN_CNT_W,
    parameter int WIN_W = SNN_WIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axon,
    input  logic [WIN_W-1:0] window_len,
    input  logic             rate_ready,
    output logic             rate_valid,
    output logic [CNT_W-1:0] rate_data,
    output logic             overrun
`ifdef SPIKE_RATE_DECODER_ISI_EN
   ,output logic [WIN_W-1:0] isi
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dec_state_t       state;
    logic [WIN_W-1:0] cyc;
    logic [WIN_W-1:0] win_len_r;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             spike;
    logic             close;
    logic             out_free;

    spike_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .axon  (axon),
        .spike (spike)
    );

    assign cnt_nxt  = (spike && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    assign close    = (state == COUNT) && (cyc == win_len_r);
    // The output register can take a new result if empty or being drained this cycle.
    assign out_free = !rate_valid || rate_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cyc        <= '0;
            win_len_r  <= '0;
            cnt        <= '0;
            rate_valid <= 1'b0;
            rate_data  <= '0;
            overrun    <= 1'b0;
        end else begin
            if (rate_valid && rate_ready)
                rate_valid <= 1'b0;

            if (close) begin
                if (out_free) begin
                    rate_valid <= 1'b1;
                    rate_data  <= cnt_nxt;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (window_len != '0) begin
                        win_len_r <= window_len;
                        cyc       <= WIN_W'(1);
                        cnt       <= CNT_W'(spike);
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    if (close) begin
                        cyc <= WIN_W'(1);
                        cnt <= '0;
                        if (window_len == '0) state <= IDLE;
                        else                  win_len_r <= window_len;
                    end else begin
                        cyc <= cyc + WIN_W'(1);
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_RATE_DECODER_ISI_EN
    localparam logic [WIN_W-1:0] IVL_MAX = '1;

    logic [WIN_W-1:0] ivl_cnt;
    logic             seen;

    // Interval timer runs regardless of windowing; isi only updates once a prior spike exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            ivl_cnt <= '0;
            isi     <= '0;
            seen    <= 1'b0;
        end else if (spike) begin
            if (seen) isi <= ivl_cnt;
            ivl_cnt <= WIN_W'(1);
            seen    <= 1'b1;
        end else if (seen && ivl_cnt != IVL_MAX) begin
            ivl_cnt <= ivl_cnt + WIN_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: vector table plus hand sequences, scoreboard on handshakes.
module tb_spike_rate_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       axon = 1'b0;
    logic       rate_ready = 1'b0;
    logic [7:0] window_len = 8'd0;
    logic       rate_valid, overrun;
    logic [7:0] rate_data;
    logic       rate_valid2, overrun2;
    logic [1:0] rate_data2;
`ifdef SPIKE_RATE_DECODER_ISI_EN
    logic [7:0] isi, isi2;
`endif

    int errors = 0;
    int checks = 0;
    int sb[$];

    typedef struct {
        int              wl;
        int              per;
        int              ncyc;
        int              nexp;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    spike_rate_decoder u_dut (
        .clk        (clk),
        .rst        (rst),
        .axon       (axon),
        .window_len (window_len),
        .rate_ready (rate_ready),
        .rate_valid (rate_valid),
        .rate_data  (rate_data),
        .overrun    (overrun)
`ifdef SPIKE_RATE_DECODER_ISI_EN
       ,.isi        (isi)
`endif
    );

    spike_rate_decoder #(.CNT_W(2), .WIN_W(8)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .axon       (axon),
        .window_len (window_len),
        .rate_ready (rate_ready),
        .rate_valid (rate_valid2),
        .rate_data  (rate_data2),
        .overrun    (overrun2)
`ifdef SPIKE_RATE_DECODER_ISI_EN
       ,.isi        (isi2)
`endif
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Drive axon for the coming edge, score any handshake that edge will take, advance one cycle.
    task automatic step(input logic a);
        int e;
        axon = a;
        @(negedge clk);
        if (rate_valid && rate_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got=%0d exp=none", rate_data);
            end else begin
                e = sb.pop_front();
                if (int'(rate_data) !== e) begin
                    errors++;
                    $display("FAIL sb_data got=%0d exp=%0d", rate_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    function automatic logic ax_of(input int per, input int k);
        if (per == 0) return 1'b0;
        if (per == 1) return 1'b1;
        return (k % per) == 0;
    endfunction

    initial begin
        vecs[0] = '{wl: 10, per: 3, ncyc: 42, nexp: 4, exp: {8'd3, 8'd4, 8'd3, 8'd4}};
        vecs[1] = '{wl: 4,  per: 1, ncyc: 14, nexp: 3, exp: {8'd0, 8'd0, 8'd0, 8'd1}};
        vecs[2] = '{wl: 1,  per: 2, ncyc: 6,  nexp: 4, exp: {8'd1, 8'd0, 8'd1, 8'd1}};
        vecs[3] = '{wl: 7,  per: 0, ncyc: 16, nexp: 2, exp: {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[4] = '{wl: 0,  per: 3, ncyc: 10, nexp: 0, exp: {8'd0, 8'd0, 8'd0, 8'd0}};

        rst_dut();
        chk("reset_valid", rate_valid, 0);
        chk("reset_data", rate_data, 0);
        chk("reset_overrun", overrun, 0);
`ifdef SPIKE_RATE_DECODER_ISI_EN
        chk("reset_isi", isi, 0);
`endif

        for (int v = 0; v < 5; v++) begin
            window_len = 8'(vecs[v].wl);
            rate_ready = 1'b1;
            rst_dut();
            for (int i = 0; i < vecs[v].nexp; i++) sb.push_back(int'(vecs[v].exp[i]));
            for (int k = 0; k < vecs[v].ncyc; k++) step(ax_of(vecs[v].per, k));
            chk($sformatf("vec%0d_drain", v), sb.size(), 0);
            chk($sformatf("vec%0d_overrun", v), overrun, 0);
        end

        // Saturation: 10 spikes in one window on a 2-bit counter must stick at 3.
        window_len = 8'd20;
        rate_ready = 1'b0;
        rst_dut();
        for (int k = 0; k < 22; k++) step(k % 2 == 1);
        chk("sat_valid", rate_valid2, 1);
        chk("sat_data", rate_data2, 3);
        chk("sat_wide_data", rate_data, 10);

        // Back-pressure: window 2 result dropped, window 3 result delivered after drain.
        window_len = 8'd5;
        rate_ready = 1'b0;
        rst_dut();
        sb.push_back(1);
        sb.push_back(3);
        for (int k = 0; k < 18; k++) begin
            rate_ready = (k >= 12);
            step(k == 2 || k == 7 || k == 9 || k == 11 || k == 13 || k == 15);
            if (k == 11) begin
                chk("hold_valid", rate_valid, 1);
                chk("hold_data", rate_data, 1);
                chk("overrun_set", overrun, 1);
            end
        end
        chk("bp_drain", sb.size(), 0);
        chk("overrun_sticky", overrun, 1);
        rst_dut();
        chk("overrun_rst", overrun, 0);

        // Accept exactly on the close cycle: old result out, new result in, no overrun.
        window_len = 8'd3;
        rst_dut();
        sb.push_back(1);
        for (int k = 0; k < 8; k++) begin
            rate_ready = (k == 6);
            step(k == 1 || k == 4 || k == 6);
            if (k == 6) begin
                chk("swap_valid", rate_valid, 1);
                chk("swap_data", rate_data, 2);
                chk("swap_overrun", overrun, 0);
            end
        end
        chk("swap_drain", sb.size(), 0);
        chk("swap_overrun_end", overrun, 0);

        // Reset mid-window discards the partial count; window_len=0 keeps it idle.
        window_len = 8'd10;
        rate_ready = 1'b1;
        rst_dut();
        for (int k = 0; k < 5; k++) step(k == 1 || k == 3);
        rst = 1'b1;
        window_len = 8'd0;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) step(k % 2 == 0);
        chk("midrst_valid", rate_valid, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_drain", sb.size(), 0);

`ifdef SPIKE_RATE_DECODER_ISI_EN
        window_len = 8'd0;
        rst_dut();
        for (int k = 0; k < 14; k++) begin
            step(k == 3 || k == 10 || k == 12);
            if (k == 3)  chk("isi_first", isi, 0);
            if (k == 10) chk("isi_7", isi, 7);
            if (k == 12) chk("isi_2", isi, 2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
